// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI link among NREQ requesters; optional WAIT timeout via SPI_ARB_TIMEOUT_EN.
// Grant 1 cycle after req in IDLE; ack 1 cycle after the first registered rise of spi_done in WAIT; req is held until own ack.
module spi_txn_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 12,
  parameter int NEWD_HOLD = 48,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic               err,
  output logic               spi_newd,
  output logic [DW-1:0]      spi_din,
  input  logic               spi_done,
  input  logic [DW-1:0]      spi_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(NEWD_HOLD + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]   din_q, din_d;
  logic            newd_q, newd_d;
  logic            done_q, done_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            edge_det;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   wcnt_q, wcnt_d;
  logic            err_q, err_d;
`endif

  // Rotated priority: lowest requester at or above rr wins, else lowest overall.
  logic            pick_vld, hit_hi;
  logic [IW-1:0]   pick_idx, hi_idx, lo_idx;
  logic [DW-1:0]   pick_word;

  always_comb begin
    pick_vld  = 1'b0;
    hit_hi    = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    pick_word = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        pick_vld = 1'b1;
        lo_idx   = IW'(j);
        if (IW'(j) >= rr_q) begin
          hit_hi = 1'b1;
          hi_idx = IW'(j);
        end
      end
    end
    pick_idx = hit_hi ? hi_idx : lo_idx;
    for (int j = 0; j < NREQ; j++) begin
      if (IW'(j) == pick_idx) pick_word = wdata[j*DW +: DW];
    end
  end

  // done_q tracks spi_done every cycle so a level already high at WAIT entry is not an edge.
  assign done_d   = spi_done;
  assign edge_det = spi_done & ~done_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    din_d   = din_q;
    newd_d  = newd_q;
    hold_d  = hold_q;
`ifdef SPI_ARB_TIMEOUT_EN
    wcnt_d  = wcnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          idx_d   = pick_idx;
          din_d   = pick_word;
          gnt_d   = NREQ'(1) << pick_idx;
          newd_d  = 1'b1;
          hold_d  = '0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (hold_q == HW'(NEWD_HOLD - 1)) begin
          newd_d  = 1'b0;
          state_d = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
          wcnt_d  = '0;
`endif
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (edge_det) begin
          ack_d   = gnt_q;
          rdata_d = spi_dout;
          state_d = S_ACK;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          ack_d   = gnt_q;
          err_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      S_ACK: begin
        gnt_d   = '0;
        rr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      din_q   <= '0;
      newd_q  <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      din_q   <= din_d;
      newd_q  <= newd_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != S_IDLE);
  assign spi_newd = newd_q;
  assign spi_din  = din_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
